softmax_norm: RTL and testbench



---
 rtl/softmax_pkg.sv | 23 ++
 rtl/seq_divider.sv | 68 ++++++
 rtl/softmax_norm.sv | 128 ++++++++++++
 tb/tb_softmax_norm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared types, widths and exp-word decode for the softmax normalizer
package softmax_pkg;

  localparam int EXP_W  = 21;
  localparam int POS_W  = 5;
  localparam int MANT_W = 16;
  localparam int FIX_W  = 32;

  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [MANT_W-1:0] mant;
  } exp_word_t;

  typedef enum logic [1:0] {COLLECT, DIVIDE, OUTPUT} state_t;

  // Q16.16 fixed form of an exp word; positions above 16 saturate at 16
  function automatic logic [FIX_W-1:0] exp_to_fix(input exp_word_t w);
    logic [POS_W-1:0] p;
    p = (w.pos > POS_W'(16)) ? POS_W'(16) : w.pos;
    return FIX_W'(w.mant) << p;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle
module seq_divider #(
  parameter int DIVIDEND_W = 48,
  parameter int DIVISOR_W  = 35,
  parameter int QUO_W      = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUO_W-1:0]      quotient
);

  localparam int REM_W = DIVISOR_W + 1;
  localparam int CNT_W = $clog2(QUO_W + 1);

  logic [REM_W-1:0]     rem, rem_cur, shifted, trial;
  logic [QUO_W-1:0]     low;
  logic [DIVISOR_W-1:0] dsr, dsr_cur;
  logic [CNT_W-1:0]     cnt;
  logic                 bit_cur, fits;

  // The start edge already resolves the first quotient bit; the bits above
  // QUO_W are preloaded as the remainder, so callers must keep them below divisor.
  always_comb begin
    rem_cur = start ? REM_W'(dividend >> QUO_W) : rem;
    bit_cur = start ? dividend[QUO_W-1] : low[QUO_W-1];
    dsr_cur = start ? divisor : dsr;
    shifted = {rem_cur[DIVISOR_W-1:0], bit_cur};
    fits    = shifted >= {1'b0, dsr_cur};
    trial   = shifted - {1'b0, dsr_cur};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      low      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        dsr      <= divisor;
        rem      <= fits ? trial : shifted;
        low      <= dividend[QUO_W-1:0] << 1;
        quotient <= QUO_W'(fits);
        cnt      <= CNT_W'(QUO_W - 1);
      end else if (busy) begin
        rem      <= fits ? trial : shifted;
        low      <= low << 1;
        quotient <= {quotient[QUO_W-2:0], fits};
        cnt      <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// rtl/softmax_norm.sv - buffers one exp vector, then emits each element over the vector sum
module softmax_norm
  import softmax_pkg::*;
#(
  parameter int N     = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = FIX_W + $clog2(N);
  localparam int QUO_W = OUT_W + 1;
  localparam int DVD_W = FIX_W + OUT_W;

  state_t            state;
  exp_word_t         in_word;
  logic [CNT_W-1:0]  count, idx;
  logic [SUM_W-1:0]  sum, sum_next, divisor;
  logic [FIX_W-1:0]  fix_buf [N];
  logic [FIX_W-1:0]  fix_in, div_fix;
  logic [QUO_W-1:0]  quotient;
  logic              launched, accept, last_beat, div_start, div_busy, div_done;

  assign in_word = in_exp;

  // The first divide launches on the closing input beat, before that beat
  // reaches the buffer or the sum register, so operands bypass them here.
  always_comb begin
    fix_in    = exp_to_fix(in_word);
    sum_next  = sum + SUM_W'(fix_in);
    accept    = (state == COLLECT) && in_valid && in_ready;
    last_beat = in_last || (count == CNT_W'(N - 1));
    div_fix   = (state == COLLECT) ? ((count == '0) ? fix_in : fix_buf[0])
                                   : fix_buf[idx[IDX_W-1:0]];
    divisor   = (state == COLLECT) ? sum_next : sum;
    div_start = (accept && last_beat && (sum_next != '0)) ||
                ((state == DIVIDE) && !launched && !div_busy && (sum != '0));
  end

  seq_divider #(.DIVIDEND_W(DVD_W), .DIVISOR_W(SUM_W), .QUO_W(QUO_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({div_fix, OUT_W'(0)}),
    .divisor  (divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk) begin
    if (accept) fix_buf[count[IDX_W-1:0]] <= fix_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      count     <= '0;
      idx       <= '0;
      sum       <= '0;
      launched  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            sum   <= sum_next;
            count <= count + CNT_W'(1);
            if (last_beat) begin
              state    <= DIVIDE;
              in_ready <= 1'b0;
              idx      <= '0;
              launched <= (sum_next != '0);
            end
          end
        end
        DIVIDE: begin
          if (sum == '0) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_data  <= '0;
            out_last  <= (idx == count - CNT_W'(1));
          end else if (div_start) begin
            launched <= 1'b1;
          end else if (div_done) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_data  <= quotient[OUT_W] ? '1 : quotient[OUT_W-1:0];
            out_last  <= (idx == count - CNT_W'(1));
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state    <= COLLECT;
              count    <= '0;
              sum      <= '0;
              idx      <= '0;
              in_ready <= 1'b1;
            end else begin
              state    <= DIVIDE;
              idx      <= idx + CNT_W'(1);
              launched <= 1'b0;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// tb/tb_softmax_norm.sv - directed and randomized checks of softmax_norm against an arithmetic model
module tb_softmax_norm;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [20:0] in_exp;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  softmax_norm #(.N(8), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  int checks = 0;
  int errors = 0;
  longint unsigned vf[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned fixv(input int p, input int m);
    return longint'(m) << ((p > 16) ? 16 : p);
  endfunction

  function automatic logic [15:0] prob(input longint unsigned f, input longint unsigned s);
    longint unsigned q;
    if (s == 0) return 16'h0000;
    q = (f << 16) / s;
    return (q > 65535) ? 16'hFFFF : q[15:0];
  endfunction

  task automatic send(input int p, input int m, input bit last);
    int n = 0;
    logic [4:0]  pp = p[4:0];
    logic [15:0] mm = m[15:0];
    in_exp   = {pp, mm};
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    vf.push_back(fixv(p, m));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Drains one vector; stall_at selects an element held off by 5 cycles of backpressure
  task automatic recv(input int stall_at);
    longint unsigned s = 0;
    int cyc;
    int n = vf.size();
    logic [15:0] e;
    foreach (vf[k]) s += vf[k];
    for (int j = 0; j < n; j++) begin
      wait_valid(cyc);
      e = prob(vf[j], s);
      chk("out_valid", out_valid, 1);
      chk("latency", cyc, (s == 0) ? 1 : ((j == 0) ? 17 : 18));
      chk("out_data", out_data, e);
      chk("out_last", out_last, (j == n - 1));
      chk("in_ready_busy", in_ready, 0);
      if (j == stall_at) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, e);
          chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("in_ready_after_hs", in_ready, (j == n - 1));
    end
    vf.delete();
  endtask

  initial begin
    int len, p, m, stall;
    bit last;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_exp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_post_reset", in_ready, 1);

    // two unequal values
    send(16, 1, 0); send(16, 3, 1);
    chk("model_0x4000", prob(vf[0], vf[0] + vf[1]), 16'h4000);
    recv(-1);

    // single saturating element
    send(10, 'h1234, 1);
    recv(-1);

    // implicit last at N
    for (int k = 0; k < 8; k++) send(16, 'h8000, 0);
    chk("implicit_last_ready", in_ready, 0);
    recv(-1);

    // backpressure on a middle element
    send(16, 1, 0); send(16, 2, 0); send(16, 5, 1);
    recv(1);

    // zero sum: no divide latency
    send(3, 0, 0); send(3, 0, 0); send(20, 0, 1);
    recv(-1);

    // reset in the middle of a divide
    send(16, 1, 0); send(16, 5, 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vf.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid2", out_valid, 0);
    send(16, 1, 0); send(16, 1, 1);
    recv(-1);

    // randomized vectors
    for (int v = 0; v < 12; v++) begin
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        p = $urandom_range(0, 31);
        m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 65535);
        last = (k == len - 1) && ((len < 8) || ($urandom_range(0, 1) == 1));
        send(p, m, last);
      end
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      recv(stall);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
